// File: rtl/dsp_mode_bits_loader.sv
// Serial runtime configuration receiver: rebuilds the 84-bit DSP mode word from an
// LSB-first frame, verifies its 4-bit nibble-XOR checksum and commits it atomically.
module dsp_mode_bits_loader #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        cfg_start_i,
  input  logic        cfg_valid_i,
  input  logic        cfg_data_i,
  output logic [83:0] mode_bits_o,
  output logic [19:0] coeff_0_o,
  output logic [19:0] coeff_1_o,
  output logic [19:0] coeff_2_o,
  output logic [19:0] coeff_3_o,
  output logic [2:0]  output_select_o,
  output logic        register_inputs_o,
  output logic        busy_o,
  output logic        cfg_done_o,
  output logic        cfg_error_o,
  output logic [1:0]  err_code_o
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CHKSUM  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_RESTART = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [83:0] shift_q, shift_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [3:0]  acc_q, acc_d;
  logic [3:0]  chk_q, chk_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [83:0] mode_q, mode_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [3:0]  rx_chk;

  // Received checksum as it will look once the current bit is shifted in.
  assign rx_chk = {cfg_data_i, chk_q[3:1]};

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    chk_d      = chk_q;
    tmo_d      = tmo_q;
    mode_d     = mode_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    err_code_d = err_code_q;

    if (cfg_start_i) begin
      // A start always opens a fresh frame; mid-frame it first aborts the old one.
      if (state_q != IDLE) begin
        error_d    = 1'b1;
        err_code_d = ERR_RESTART;
      end else begin
        err_code_d = ERR_NONE;
      end
      state_d = PAYLOAD;
      shift_d = '0;
      cnt_d   = '0;
      acc_d   = '0;
      chk_d   = '0;
      tmo_d   = '0;
      if (cfg_valid_i) begin
        shift_d = {cfg_data_i, 83'd0};
        acc_d   = {3'b000, cfg_data_i};
        cnt_d   = 7'd1;
      end
    end else begin
      case (state_q)
        PAYLOAD, CHECK: begin
          if (cfg_valid_i) begin
            tmo_d = '0;
            cnt_d = cnt_q + 7'd1;
            if (state_q == PAYLOAD) begin
              shift_d = {cfg_data_i, shift_q[83:1]};
              acc_d[cnt_q[1:0]] = acc_q[cnt_q[1:0]] ^ cfg_data_i;
              if (cnt_q == 7'd83) begin
                state_d = CHECK;
              end
            end else begin
              chk_d = rx_chk;
              if (cnt_q == 7'd87) begin
                state_d = IDLE;
                if (rx_chk == acc_q) begin
                  mode_d = shift_q;
                  done_d = 1'b1;
                end else begin
                  error_d    = 1'b1;
                  err_code_d = ERR_CHKSUM;
                end
              end
            end
          end else if (TIMEOUT_CYCLES != 0 && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d    = IDLE;
            error_d    = 1'b1;
            err_code_d = ERR_TIMEOUT;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      chk_q      <= '0;
      tmo_q      <= '0;
      mode_q     <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      chk_q      <= chk_d;
      tmo_q      <= tmo_d;
      mode_q     <= mode_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
    end
  end

  assign mode_bits_o       = mode_q;
  assign coeff_0_o         = mode_q[19:0];
  assign coeff_1_o         = mode_q[39:20];
  assign coeff_2_o         = mode_q[59:40];
  assign coeff_3_o         = mode_q[79:60];
  assign output_select_o   = mode_q[82:80];
  assign register_inputs_o = mode_q[83];
  assign busy_o            = (state_q != IDLE);
  assign cfg_done_o        = done_q;
  assign cfg_error_o       = error_q;
  assign err_code_o        = err_code_q;

endmodule

// File: tb/tb_dsp_mode_bits_loader.sv
// Directed bench for dsp_mode_bits_loader: frames, checksum errors, timeouts,
// restarts and resets, each checked against hand-computed values.
module tb_dsp_mode_bits_loader;

  logic        clk = 1'b0;
  logic        rst, start, valid, data;
  logic [83:0] mode_bits;
  logic [19:0] c0, c1, c2, c3;
  logic [2:0]  osel;
  logic        rin, busy, done, err;
  logic [1:0]  ecode;

  int n_cmp = 0;
  int n_bad = 0;

  // coeff_0=12345, output_select=5, register_inputs=1; nibble XOR 5^4^3^2^1^D = C
  localparam logic [83:0] GOOD = {1'b1, 3'b101, 20'h0, 20'h0, 20'h0, 20'h12345};
  localparam logic [83:0] ALT  = {1'b0, 3'b010, 80'h1};

  dsp_mode_bits_loader #(.TIMEOUT_CYCLES(16)) dut (
    .clock_i(clk), .reset_i(rst), .cfg_start_i(start), .cfg_valid_i(valid),
    .cfg_data_i(data), .mode_bits_o(mode_bits), .coeff_0_o(c0), .coeff_1_o(c1),
    .coeff_2_o(c2), .coeff_3_o(c3), .output_select_o(osel),
    .register_inputs_o(rin), .busy_o(busy), .cfg_done_o(done),
    .cfg_error_o(err), .err_code_o(ecode)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic s, input logic b);
    start = s; valid = 1'b1; data = b;
    step();
    start = 1'b0; valid = 1'b0; data = 1'b0;
  endtask

  task automatic send_bits(input logic [83:0] w, input logic [3:0] c,
                           input int from, input int to, input logic with_start);
    logic b;
    for (int i = from; i <= to; i++) begin
      if (i < 84) b = w[i];
      else        b = c[i - 84];
      drive_bit(with_start && (i == from), b);
    end
  endtask

  task automatic test_reset();
    logic pulse_seen;
    rst = 1'b1; start = 1'b0; valid = 1'b0; data = 1'b0;
    step(); step();
    rst = 1'b0;
    n_cmp++;
    if ({mode_bits, busy, done, err, ecode} !== 89'd0) begin
      n_bad++; $display("FAIL reset_outputs: got mode=%h busy=%b done=%b err=%b code=%b, need all 0",
                        mode_bits, busy, done, err, ecode);
    end
    pulse_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (done || err || busy || mode_bits != 84'd0) pulse_seen = 1'b1;
    end
    n_cmp++;
    if (pulse_seen !== 1'b0) begin
      n_bad++; $display("FAIL reset_idle: activity seen=%b, need 0", pulse_seen);
    end
    $display("reset/idle: 100 quiet cycles checked");
  endtask

  task automatic test_good();
    send_bits(GOOD, 4'hC, 0, 86, 1'b1);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL good_before_last: done=%b busy=%b, need 0/1", done, busy);
    end
    drive_bit(1'b0, 1'b1);
    n_cmp++;
    if (done !== 1'b1 || mode_bits !== GOOD) begin
      n_bad++; $display("FAIL good_commit: done=%b mode=%h, need 1/%h", done, mode_bits, GOOD);
    end
    n_cmp++;
    if (c0 !== 20'h12345 || osel !== 3'd5 || rin !== 1'b1 || mode_bits[83:80] !== 4'hD
        || c1 !== 20'h0 || c2 !== 20'h0 || c3 !== 20'h0) begin
      n_bad++; $display("FAIL good_fields: c0=%h osel=%0d rin=%b top=%h, need 12345/5/1/d",
                        c0, osel, rin, mode_bits[83:80]);
    end
    n_cmp++;
    if (busy !== 1'b0 || err !== 1'b0 || ecode !== 2'b00) begin
      n_bad++; $display("FAIL good_status: busy=%b err=%b code=%b, need 0/0/00", busy, err, ecode);
    end
    step();
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++; $display("FAIL good_done_width: done=%b, need 0", done);
    end
    $display("good frame: mode=%h", mode_bits);
  endtask

  task automatic test_bad_checksum();
    send_bits(GOOD, 4'h3, 0, 87, 1'b1);
    n_cmp++;
    if (err !== 1'b1 || ecode !== 2'b01 || done !== 1'b0 || mode_bits !== GOOD) begin
      n_bad++; $display("FAIL bad_chk: err=%b code=%b done=%b mode=%h, need 1/01/0/%h",
                        err, ecode, done, mode_bits, GOOD);
    end
    step();
    n_cmp++;
    if (err !== 1'b0 || ecode !== 2'b01) begin
      n_bad++; $display("FAIL bad_chk_hold: err=%b code=%b, need 0/01", err, ecode);
    end
    $display("bad checksum: code=%b", ecode);
  endtask

  task automatic test_gap15();
    send_bits(GOOD, 4'hC, 0, 39, 1'b1);
    n_cmp++;
    if (ecode !== 2'b00) begin
      n_bad++; $display("FAIL start_clears_code: code=%b, need 00", ecode);
    end
    for (int i = 0; i < 15; i++) step();
    n_cmp++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      n_bad++; $display("FAIL gap15_stall: busy=%b err=%b, need 1/0", busy, err);
    end
    send_bits(GOOD, 4'hC, 40, 87, 1'b0);
    n_cmp++;
    if (done !== 1'b1 || mode_bits !== GOOD) begin
      n_bad++; $display("FAIL gap15_commit: done=%b mode=%h, need 1/%h", done, mode_bits, GOOD);
    end
    $display("gap 15: done=%b", done);
  endtask

  task automatic test_gap16();
    logic done_seen;
    send_bits(GOOD, 4'hC, 0, 39, 1'b1);
    for (int i = 0; i < 15; i++) step();
    n_cmp++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL gap16_early: err=%b busy=%b, need 0/1", err, busy);
    end
    step();
    n_cmp++;
    if (err !== 1'b1 || ecode !== 2'b10 || busy !== 1'b0) begin
      n_bad++; $display("FAIL gap16_timeout: err=%b code=%b busy=%b, need 1/10/0", err, ecode, busy);
    end
    done_seen = 1'b0;
    for (int i = 40; i <= 87; i++) begin
      drive_bit(1'b0, (i < 84) ? GOOD[i] : 1'b1);
      if (done) done_seen = 1'b1;
    end
    n_cmp++;
    if (done_seen !== 1'b0 || busy !== 1'b0 || ecode !== 2'b10) begin
      n_bad++; $display("FAIL gap16_no_commit: done_seen=%b busy=%b code=%b, need 0/0/10",
                        done_seen, busy, ecode);
    end
    $display("gap 16: code=%b", ecode);
  endtask

  task automatic test_restart_boundaries();
    send_bits(ALT, 4'h0, 0, 86, 1'b1);
    drive_bit(1'b1, 1'b0);
    n_cmp++;
    if (err !== 1'b1 || ecode !== 2'b11 || done !== 1'b0 || mode_bits !== GOOD || busy !== 1'b1) begin
      n_bad++; $display("FAIL restart_at_last: err=%b code=%b done=%b busy=%b mode=%h, need 1/11/0/1/%h",
                        err, ecode, done, busy, mode_bits, GOOD);
    end
    for (int i = 0; i < 15; i++) step();
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++;
    if (err !== 1'b1 || ecode !== 2'b11 || busy !== 1'b1) begin
      n_bad++; $display("FAIL restart_vs_timeout: err=%b code=%b busy=%b, need 1/11/1", err, ecode, busy);
    end
    $display("restart boundaries: code=%b", ecode);
  endtask

  task automatic test_restart();
    send_bits(GOOD, 4'hC, 0, 49, 1'b1);
    drive_bit(1'b1, 1'b0);
    n_cmp++;
    if (err !== 1'b1 || ecode !== 2'b11 || busy !== 1'b1 || done !== 1'b0) begin
      n_bad++; $display("FAIL restart_bit50: err=%b code=%b busy=%b done=%b, need 1/11/1/0",
                        err, ecode, busy, done);
    end
    send_bits(84'd0, 4'h0, 1, 87, 1'b0);
    n_cmp++;
    if (done !== 1'b1 || mode_bits !== 84'd0 || c0 !== 20'd0 || osel !== 3'd0 || rin !== 1'b0) begin
      n_bad++; $display("FAIL restart_zero_commit: done=%b mode=%h, need 1/0", done, mode_bits);
    end
    $display("restart then zero frame: mode=%h", mode_bits);
  endtask

  task automatic test_reset_in_check();
    send_bits(GOOD, 4'hC, 0, 87, 1'b1);
    n_cmp++;
    if (mode_bits !== GOOD) begin
      n_bad++; $display("FAIL prior_commit: mode=%h, need %h", mode_bits, GOOD);
    end
    send_bits(GOOD, 4'hC, 0, 85, 1'b1);
    rst = 1'b1; valid = 1'b1; data = 1'b1;
    step();
    rst = 1'b0; valid = 1'b0;
    n_cmp++;
    if (mode_bits !== 84'd0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || ecode !== 2'b00) begin
      n_bad++; $display("FAIL reset_in_check: mode=%h busy=%b done=%b err=%b code=%b, need all 0",
                        mode_bits, busy, done, err, ecode);
    end
    drive_bit(1'b0, 1'b1);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || mode_bits !== 84'd0) begin
      n_bad++; $display("FAIL reset_no_commit: done=%b busy=%b mode=%h, need 0/0/0", done, busy, mode_bits);
    end
    $display("reset during CHECK: busy=%b", busy);
  endtask

  initial begin
    test_reset();
    test_good();
    test_bad_checksum();
    test_gap15();
    test_gap16();
    test_restart_boundaries();
    test_restart();
    test_reset_in_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, need completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dsp_mode_bits_loader.md
Name: dsp_mode_bits_loader

Overview:
Runtime configuration receiver for the DSP tile. It accepts a serial configuration frame, rebuilds the 84-bit DSP mode word and checks a 4-bit checksum. It then commits the word atomically as unpacked fields: COEFF_0..3, OUTPUT_SELECT and REGISTER_INPUTS. This is the inverse of the static mode-bit packing: configuration arrives as a bitstream at run time and is decoded back into fields.

Parameters:
TIMEOUT_CYCLES, 16, consecutive cycles with no cfg_valid_i allowed mid-frame before abort; 0 disables the timeout.

Ports:
clock_i  input  1  DSP clock
reset_i  input  1  synchronous active-high reset
cfg_start_i  input  1  frame start strobe
cfg_valid_i  input  1  qualifies cfg_data_i
cfg_data_i  input  1  serial config bit, LSB-first
mode_bits_o  output  84  committed word {register_inputs, output_select[2:0], coeff_3, coeff_2, coeff_1, coeff_0}
coeff_0_o  output  20  mode_bits_o[19:0]
coeff_1_o  output  20  mode_bits_o[39:20]
coeff_2_o  output  20  mode_bits_o[59:40]
coeff_3_o  output  20  mode_bits_o[79:60]
output_select_o  output  3  mode_bits_o[82:80]
register_inputs_o  output  1  mode_bits_o[83]
busy_o  output  1  frame in progress
cfg_done_o  output  1  one-cycle pulse on successful commit
cfg_error_o  output  1  one-cycle pulse on any frame failure
err_code_o  output  2  00 none, 01 checksum, 10 timeout, 11 aborted by restart

Behaviour:
- One clock (clock_i). Reset is synchronous, active-high, on reset_i.
- Reset values:
  - All config outputs 0.
  - busy_o, cfg_done_o, cfg_error_o are 0.
  - err_code_o is 00.
  - FSM goes to IDLE.
  - Shift register, bit counter, checksum accumulator and timeout counter are cleared.
- Reset mid-frame discards the partial frame and clears the committed config.
- Frame format: 84 payload bits (bit 0 first = coeff_0[0]), then 4 checksum bits, LSB-first.
- Checksum = XOR of the 21 payload nibbles (nibble k = bits 4k+3..4k). It is accumulated on the fly: acc[i%4] ^= bit i.
- FSM states: IDLE, PAYLOAD, CHECK.
  - IDLE: on cfg_start_i go to PAYLOAD.
    - If cfg_valid_i is high in the same cycle, that bit is payload bit 0.
    - err_code_o clears to 00 on any cfg_start_i.
  - PAYLOAD: each cycle with cfg_valid_i high shifts in one bit and increments the counter (0..83). After bit 83 is accepted, go to CHECK.
  - CHECK: accept 4 checksum bits. On the 4th accepted bit, return to IDLE and compare received vs computed checksum.
    - Match: in the next cycle mode_bits_o and all fields update together, and cfg_done_o=1 for one cycle.
    - Mismatch: config is unchanged, cfg_error_o pulses, err_code_o=01.
- Latency: outputs are visible exactly 1 cycle after the last checksum bit is sampled.
- Invalid cycles (cfg_valid_i low) stall the frame; cfg_data_i is ignored.
- Timeout: a counter runs in PAYLOAD/CHECK while cfg_valid_i is low and resets on every valid bit.
  - When it reaches TIMEOUT_CYCLES: go to IDLE, pulse cfg_error_o, set err_code_o=10.
  - Config is unchanged.
- cfg_start_i in PAYLOAD or CHECK:
  - The current frame is dropped; cfg_error_o pulses and err_code_o=11.
  - The new frame starts the same cycle, with the same-cycle data rule as in IDLE.
  - This takes priority over a completing 4th checksum bit in that cycle: no commit.
- cfg_start_i and a timeout expiry in the same cycle: restart wins; err_code_o=11.
- busy_o=1 in PAYLOAD/CHECK, 0 in IDLE.
- err_code_o holds until the next cfg_start_i or reset.
- The committed config is never partially updated.

Test Plan:
- Reset then idle:
  - Stimulus: reset_i high for 2 cycles, then low.
  - Required: all outputs 0, busy_o=0, no pulses for 100 cycles.
- Good frame, continuous valid:
  - Stimulus: coeff_0=20'h12345, coeff_1..3=0, output_select=3'b101, register_inputs=1, checksum 4'hC.
  - Required: cfg_done_o one cycle after the last bit; coeff_0_o=20'h12345, output_select_o=5, register_inputs_o=1, mode_bits_o[83:80]=4'hD.
- Same frame with checksum 4'h3:
  - Required: cfg_error_o pulse, err_code_o=01, outputs keep the previous values.
- Same good frame with cfg_valid_i deasserted for 15 cycles at bit 40:
  - Required: commit succeeds.
- Same good frame with a 16-cycle gap:
  - Required: error with err_code_o=10, no commit, busy_o drops.
- cfg_start_i asserted at payload bit 50, then a full good frame (all-zero payload, checksum 0):
  - Required: cfg_error_o pulses with err_code_o=11 at bit 50, then cfg_done_o, all config outputs 0.
- reset_i asserted during CHECK after a prior good commit:
  - Required: next cycle all outputs 0 and busy_o=0; no cfg_done_o.
